// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic sequencer.
// Holds the FSM state encoding, opcode map and slice B-mux select codes.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // op = {cin0, sel[1:0]}
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b000;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_NB   = 2'b10;
    localparam logic [1:0] SEL_ONE  = 2'b11;

endpackage

// File: rtl/arithmetic_unit.sv
// 1-bit arithmetic slice: full adder with a 4-way B-operand mux.
// Purely combinational; no latency, no flow control.
module arithmetic_unit
    import serial_arith_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic       d,
    output logic       cout
);

    logic b_mux;

    always_comb begin
        b_mux = 1'b0;
        unique case (sel)
            SEL_ZERO: b_mux = 1'b0;
            SEL_B:    b_mux = b;
            SEL_NB:   b_mux = ~b;
            SEL_ONE:  b_mux = 1'b1;
            default:  b_mux = 1'b0;
        endcase
    end

    assign d    = a ^ b_mux ^ cin;
    assign cout = (a & b_mux) | (a & cin) | (b_mux & cin);

endmodule

// File: rtl/serial_arith_ctrl.sv
// Bit-serial add/sub/inc/dec/transfer over one slice; done WIDTH+1 edges after accept.
// start honoured only in IDLE (no queuing); signed overflow built only with SERIAL_ARITH_OVF_EN.
module serial_arith_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [1:0]       sel_q;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             slice_d;
    logic             slice_cout;

    arithmetic_unit u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sel  (sel_q),
        .d    (slice_d),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result fills from the MSB end so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sel_q   <= SEL_ZERO;
            carry   <= 1'b0;
            bit_cnt <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            sel_q   <= op[1:0];
            carry   <= op[2];
            bit_cnt <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (state == RUN) begin
            result <= {slice_d, result[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= slice_cout;
            if (last_bit) begin
                cout <= slice_cout;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ARITH_OVF_EN
    logic ovf_q;

    // On the MSB cycle, carry still holds the carry into the sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry ^ slice_cout;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_arith_ctrl.sv
// Randomized and directed bench for serial_arith_ctrl against a whole-word arithmetic model.
module tb_serial_arith_ctrl;

    localparam int W = 32;
`ifdef SERIAL_ARITH_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_arith_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {overflow, cout, result}
    function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] ai,
                                           input logic [W-1:0] bi);
        logic [W-1:0] bm;
        logic [W:0]   sum;
        logic         ov;
        case (o[1:0])
            2'b00:   bm = '0;
            2'b01:   bm = bi;
            2'b10:   bm = ~bi;
            default: bm = '1;
        endcase
        sum = {1'b0, ai} + {1'b0, bm} + {{W{1'b0}}, o[2]};
        ov  = OVF_ON && (ai[W-1] == bm[W-1]) && (sum[W-1] != ai[W-1]);
        return {ov, sum};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] ai,
                          input logic [W-1:0] bi, input logic [W-1:0] e_res, input logic e_co,
                          input logic e_ov, input bit inject);
        int           first_done = -1;
        int           n_done = 0;
        logic [W-1:0] res_at_done = '0;
        @(negedge clk);
        op = o; a = ai; b = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, ".busy_e0"}, busy, 1);
        for (int k = 1; k <= W + 3; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done  = k;
                    res_at_done = result;
                end
            end
            if (k == W)     check_eq({tag, ".busy_last"}, busy, 1);
            if (k == W + 1) check_eq({tag, ".busy_off"}, busy, 0);
            // operands wander freely; start only re-asserted in RUN (bit 10) and DONE
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom);
            start = inject && (k == 10 || k == W);
        end
        start = 1'b0;
        check_eq({tag, ".done_edge"}, 64'(first_done), 64'(W));
        check_eq({tag, ".done_width"}, 64'(n_done), 1);
        check_eq({tag, ".res_done"}, res_at_done, e_res);
        check_eq({tag, ".res_held"}, result, e_res);
        check_eq({tag, ".cout"}, cout, e_co);
        check_eq({tag, ".ovf"}, overflow, e_ov);
    endtask

    task automatic run_model(input string tag, input logic [2:0] o, input logic [W-1:0] ai,
                             input logic [W-1:0] bi, input bit inject);
        logic [W+1:0] m;
        m = model(o, ai, bi);
        run_op(tag, o, ai, bi, m[W-1:0], m[W], m[W+1], inject);
    endtask

    task automatic reset_abort();
        int n_done = 0;
        @(negedge clk);
        op = 3'b001; a = 32'h1234_5678; b = 32'h0F0F_0F0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.result", result, 0);
        check_eq("rst.cout", cout, 0);
        check_eq("rst.ovf", overflow, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("rst.no_done", 64'(n_done), 0);
        check_eq("rst.result_hold", result, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        #12;
        check_eq("reset.busy", busy, 0);
        check_eq("reset.done", done, 0);
        check_eq("reset.result", result, 0);
        check_eq("reset.cout", cout, 0);
        check_eq("reset.ovf", overflow, 0);
        @(negedge clk) rst = 1'b0;

        run_op("add5_3",  3'b001, 32'h5,         32'h3, 32'h8,         1'b0, 1'b0, 1'b0);
        run_op("sub5_3",  3'b110, 32'h5,         32'h3, 32'h2,         1'b1, 1'b0, 1'b0);
        run_op("sub3_5",  3'b110, 32'h3,         32'h5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("inc_max", 3'b100, 32'hFFFF_FFFF, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0);
        run_op("dec_0",   3'b011, 32'h0,         32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("xfer",    3'b000, 32'hA5A5_0001, 32'hFFFF_FFFF, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
        run_op("ovf_add", 3'b001, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, OVF_ON, 1'b0);
        run_op("add1_1",  3'b001, 32'h1,         32'h1, 32'h2,         1'b0, 1'b0, 1'b0);
        run_op("ignore",  3'b001, 32'h5,         32'h3, 32'h8,         1'b0, 1'b0, 1'b1);

        reset_abort();
        run_op("post_rst", 3'b001, 32'h0001_0000, 32'h0000_FFFF, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_model($sformatf("rnd%0d", i), 3'($urandom), $urandom, $urandom, (i % 4) == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_arith_ctrl.md
# serial_arith_ctrl

Bit-serial sequencer that time-multiplexes a single `arithmetic_unit` 1-bit slice over WIDTH clock cycles to produce a full-width add, subtract, increment, decrement or transfer. It is the area-minimal alternative to the 32-slice ripple ALU datapath. It sits between the ALU command interface and one slice instance, and owns the operand shifting, the carry loop and the start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  command request; sampled only in IDLE.
- `op`  in  3  `{cin0, sel[1:0]}`:
  - `sel` drives the slice B-mux: 00 → 0, 01 → B, 10 → ~B, 11 → 1.
  - `cin0` is the initial carry.
- `a`  in  WIDTH  operand A, captured with `start`.
- `b`  in  WIDTH  operand B, captured with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  WIDTH  result register; holds its value until the next accepted command.
- `cout`  out  1  final carry out of the MSB.
- `overflow`  out  1  signed overflow (see Configuration).

## Operation
- Opcodes:
  - ADD = 3'b001
  - SUB = 3'b110
  - INC = 3'b100
  - DEC = 3'b011 (A + all-ones)
  - TRANSFER = 3'b000
  - All other opcodes execute literally per the mux table.
- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Latch `a`/`b` into shift registers `a_sh`/`b_sh` and latch `sel`.
  - Set `carry` ← `cin0` and `bit_cnt` ← 0; clear `result`, `cout`, `overflow`.
  - Go to RUN.
- RUN, every cycle:
  - Slice inputs: Ai = `a_sh[0]`, Bi = `b_sh[0]`, Cini = `carry`, sel = latched sel.
  - `result` ← `{Di, result[WIDTH-1:1]}` (LSB computed first, shifted in at the MSB).
  - `a_sh` and `b_sh` shift right by 1; `carry` ← Couti; `bit_cnt` increments.
- RUN, when `bit_cnt` == WIDTH-1:
  - `cout` ← Couti; `overflow` computed (if enabled).
  - Go to DONE.
- DONE: `done`=1 for this cycle only; unconditional transition to IDLE.
- `start` in RUN or DONE is ignored, with no queuing. A command presented in DONE must be held until IDLE.
- `bit_cnt` width is $clog2(WIDTH); it never wraps, because the terminal count ends RUN.
- Operands and `sel` changing on the inputs during RUN have no effect.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `result` 0, `cout` 0, `overflow` 0; internal registers 0.
- Reset asserted mid-operation aborts the operation immediately (asynchronously). No `done` is produced and the partial result is discarded (`result` = 0).
- Edge E0 samples `start`. `busy` is high from E0 through E(WIDTH+1).
- `done` is high in the cycle following edge E(WIDTH). `result`, `cout` and `overflow` are valid from that cycle and held.
- Latency from the start edge to the done edge is WIDTH+1 cycles. The earliest next accept is at E(WIDTH+2), so throughput is 1 op per WIDTH+2 cycles.
- The slice is purely combinational; carry is registered once per bit. The critical path is one slice plus the mux.

## Configuration
- `SERIAL_ARITH_OVF_EN` defined: on the last RUN cycle, `overflow` ← `carry` (carry into the MSB) XOR Couti, registered with `cout`.
- `SERIAL_ARITH_OVF_EN` not defined: the `overflow` port remains, tied to constant 0, and no overflow logic is generated.

## Structure
- Package `serial_arith_pkg` contains:
  - State enum {IDLE, RUN, DONE}.
  - 3-bit opcode constants OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_XFER.
  - Sel constants SEL_ZERO, SEL_B, SEL_NB, SEL_ONE.
- One sub-module: an instance of the existing `arithmetic_unit` 1-bit slice. No other hierarchy.

## Test plan
- ADD: 0x0000_0005 + 0x0000_0003 → `result` 0x0000_0008, `cout` 0. `done` exactly 33 edges after the start edge, 1 cycle wide.
- SUB:
  - 5 − 3 → 0x0000_0002, `cout` 1.
  - 3 − 5 → 0xFFFF_FFFE, `cout` 0.
- INC and DEC:
  - INC 0xFFFF_FFFF → 0x0000_0000, `cout` 1.
  - DEC 0x0000_0000 → 0xFFFF_FFFF, `cout` 0.
- Overflow, ADD 0x7FFF_FFFF + 0x0000_0001 → 0x8000_0000:
  - With `SERIAL_ARITH_OVF_EN`: `overflow` 1.
  - Without the macro: `overflow` 0.
  - ADD 0x0000_0001 + 0x0000_0001: `overflow` 0 in both builds.
- Handshake and reset:
  - `start` with new operands pulsed at bit 10 and in DONE is ignored; the original result is unchanged.
  - `rst` asserted at bit 10 forces all outputs to 0 with no `done`; a following ADD completes correctly.
